pmp_cfg_regs: RTL and testbench
===============================

# pmp_cfg_regs

Register-mapped configuration store for the combinational PMP checker: holds `NR_ENTRIES` pmpcfg bytes and pmpaddr registers, applies RISC-V WARL and lock rules on writes, and drives the `conf_i`/`conf_addr_i` inputs of the checker. It sits between a single-outstanding register bus (driven by the IO-PMP programming port) and the checker instances, and is the write side of the configuration interface the checker reads.

## Interface
- `NR_ENTRIES`, 16, implemented entries (1..16); entries at and above this index read 0 and ignore writes.
- `PMP_LEN`, 54, pmpaddr width (rv32: 32).
- `PMPGranularity`, 2, G; NA4 is unselectable when G≥1; G=0 applies no address masking.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `reg_valid_i`  in  1  request valid.
- `reg_ready_o`  out  1  request accepted when `reg_valid_i && reg_ready_o`.
- `reg_write_i`  in  1  1 = write, 0 = read.
- `reg_addr_i`  in  8  byte address.
- `reg_wdata_i`  in  64  write data.
- `reg_wstrb_i`  in  8  byte strobes (used for pmpcfg words only; pmpaddr writes need all 8 set, otherwise ignored).
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  64  read data (0 for writes and errors).
- `rsp_error_o`  out  1  decode error.
- `conf_o`  out  16×`riscv::pmpcfg_t`  entry configs to checker.
- `conf_addr_o`  out  16×`PMP_LEN`  masked pmpaddr values to checker.

## Operation
- Map (addr[2:0] must be 0): 0x00 = pmpcfg entries 0–7 (byte lane k = entry k), 0x08 = entries 8–15, 0x80+8·i = pmpaddr[i], i=0..15. Any other address or misalignment: `rsp_error_o`=1, no state change.
- cfg byte: [7] L, [6:5] reserved (read 0), [4:3] A (OFF/TOR/NA4/NAPOT), [2:0] X,W,R.
- cfg byte write (strobe set, entry implemented) is ignored entirely when: entry locked; {W,R}=2'b10; or A=NA4 with G≥1. Otherwise stored with reserved bits cleared.
- pmpaddr[i] write is ignored when cfg[i].L=1, or when i+1<NR_ENTRIES with cfg[i+1].L=1 and cfg[i+1].A=TOR. Otherwise it stores `reg_wdata_i[PMP_LEN-1:0]`.
- Address view (reads and `conf_addr_o`), G≥1: A=NAPOT → bits [G-2:0] forced 1 (none when G=1); A=OFF/TOR → bits [G-1:0] forced 0; stored value unchanged (changing A changes the view).
- Lock is sticky until reset; there is no unlock path.
- FSM: IDLE (`reg_ready_o`=1) → accept → RESP (`rsp_valid_o`=1, ready 0) → on `rsp_ready_i` → IDLE. Writes commit at the accepting edge; read data is sampled at the accepting edge and held stable in RESP.

## Timing
- Reset: all cfg 0 (OFF, unlocked), all pmpaddr 0, state IDLE, `reg_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_error_o`=0.
- Latency: response valid 1 cycle after accept; max throughput 1 request / 2 cycles.
- `conf_o`/`conf_addr_o` reflect a write from the cycle after the accepting edge; they are registered and glitch-free.
- Response held (data, error stable) while `rsp_ready_i`=0; no new request is accepted until the handshake completes.
- Reset mid-RESP: response dropped, outputs return to reset values asynchronously.
- Same-word cfg write that sets L and changes XWR in one access: both take effect (the lock check uses the pre-write value).

## Test plan
- Reset, read 0x00, 0x08, 0x80 → rdata 0, error 0; `conf_o` all OFF.
- Write 0x00 data 0x0000_0000_0000_1F0B strb 0x03 (entry0 A=TOR XWR=011, entry1 NAPOT RWX) → read back 0x1F0B; checker with U-mode read in range → allow.
- Lock: write entry1 cfg 0x8B (L,TOR,RW) then write pmpaddr0 0x1234 and entry1 cfg 0x0F → both ignored, readback unchanged; a further write to pmpaddr1 is also ignored.
- WARL: G=2, write cfg byte 0x12 (NA4) and 0x02 (W without R) → byte unchanged; pmpaddr0=0xFF with NAPOT reads 0xFF, with TOR reads 0xFC.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles with `reg_valid_i` high → `reg_ready_o`=0, rdata stable, second request accepted only after the handshake.
- Error: read 0x04 and 0x40 → error 1, rdata 0; then assert reset during RESP → `rsp_valid_o`=0 immediately, all cfg cleared.

Source files
------------

// File: rtl/pmp_cfg_regs.sv
// pmp_cfg_regs: register-mapped pmpcfg/pmpaddr store with WARL and lock rules, feeding the PMP checker
//   clk_i, rst_i (async, active high)
//   reg_*  : single-outstanding request port (valid/ready, write, byte addr, wdata, wstrb)
//   rsp_*  : response port (valid/ready, rdata, error)
//   conf_o : 16 packed cfg bytes {L, 2'b0, A[1:0], X, W, R}, entry e at [8e +: 8]
//   conf_addr_o : 16 masked pmpaddr views, entry e at [PMP_LEN*e +: PMP_LEN]
module pmp_cfg_regs #(
  parameter int unsigned NR_ENTRIES     = 16,
  parameter int unsigned PMP_LEN        = 54,
  parameter int unsigned PMPGranularity = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reg_valid_i,
  output logic                    reg_ready_o,
  input  logic                    reg_write_i,
  input  logic [7:0]              reg_addr_i,
  input  logic [63:0]             reg_wdata_i,
  input  logic [7:0]              reg_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [63:0]             rsp_rdata_o,
  output logic                    rsp_error_o,
  output logic [16*8-1:0]         conf_o,
  output logic [16*PMP_LEN-1:0]   conf_addr_o
);
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;
  // NAPOT forces bits [G-2:0] high; OFF/TOR force bits [G-1:0] low; both masks are 0 for G=0
  localparam logic [PMP_LEN-1:0] M_NAPOT = PMPGranularity >= 1 ?
    ((PMP_LEN'(1) << PMPGranularity) >> 1) - PMP_LEN'(1) : '0;
  localparam logic [PMP_LEN-1:0] M_OFF = (PMP_LEN'(1) << PMPGranularity) - PMP_LEN'(1);
  typedef enum logic {S_IDLE, S_RESP} state_t;
  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cfg  [16];
  logic [7:0]         w_cfg_nxt [16];
  logic [PMP_LEN-1:0] r_addr [16];
  logic [PMP_LEN-1:0] w_addr_nxt [16];
  logic [PMP_LEN-1:0] r_view [16];
  logic [PMP_LEN-1:0] w_view_nxt [16];
  logic [63:0]        r_rdata, w_rdata_nxt;
  logic               r_err;
  logic               w_acc, w_wr, w_is_cfg, w_is_addr, w_err;
  logic [3:0]         w_idx;
  function automatic logic cfg_legal(input logic [7:0] b);
    return b[1:0] != 2'b10 && !(b[4:3] == A_NA4 && PMPGranularity >= 1);
  endfunction
  function automatic logic [PMP_LEN-1:0] addr_view(input logic [PMP_LEN-1:0] a, input logic [1:0] m);
    return m == A_NAPOT ? a | M_NAPOT : m == A_NA4 ? a : a & ~M_OFF;
  endfunction
  assign w_acc       = reg_valid_i && r_state == S_IDLE;
  assign w_is_cfg    = reg_addr_i[2:0] == 3'b0 && reg_addr_i[7:4] == 4'h0;
  assign w_is_addr   = reg_addr_i[2:0] == 3'b0 && reg_addr_i[7];
  assign w_err       = !(w_is_cfg || w_is_addr);
  assign w_wr        = w_acc && reg_write_i && !w_err;
  assign w_idx       = reg_addr_i[6:3];
  assign reg_ready_o = r_state == S_IDLE;
  assign rsp_valid_o = r_state == S_RESP;
  assign rsp_rdata_o = r_rdata;
  assign rsp_error_o = r_err;
  always_comb begin
    w_state_nxt = r_state == S_IDLE ? (reg_valid_i ? S_RESP : S_IDLE) : (rsp_ready_i ? S_IDLE : S_RESP);
  end
  // lock checks use the pre-write cfg, so one write may set L and change XWR together
  always_comb begin
    for (int unsigned e = 0; e < 16; e++) begin
      w_cfg_nxt[e]  = r_cfg[e];
      w_addr_nxt[e] = r_addr[e];
      if (w_wr && w_is_cfg && reg_addr_i[3] == e[3] && reg_wstrb_i[e % 8] && e < NR_ENTRIES &&
          !r_cfg[e][7] && cfg_legal(reg_wdata_i[8*(e%8) +: 8]))
        w_cfg_nxt[e] = reg_wdata_i[8*(e%8) +: 8] & 8'h9F;
      if (w_wr && w_is_addr && w_idx == e[3:0] && &reg_wstrb_i && e < NR_ENTRIES && !r_cfg[e][7] &&
          !(e + 1 < NR_ENTRIES && r_cfg[4'(e + 1)][7] && r_cfg[4'(e + 1)][4:3] == A_TOR))
        w_addr_nxt[e] = reg_wdata_i[PMP_LEN-1:0];
      w_view_nxt[e] = addr_view(w_addr_nxt[e], w_cfg_nxt[e][4:3]);
    end
  end
  always_comb begin
    w_rdata_nxt = '0;
    if (!reg_write_i && w_is_cfg)
      for (int k = 0; k < 8; k++) w_rdata_nxt[8*k +: 8] = r_cfg[{reg_addr_i[3], 3'(k)}];
    else if (!reg_write_i && w_is_addr)
      w_rdata_nxt = 64'(r_view[w_idx]);
  end
  // the address view is registered from next-state values so the checker sees a glitch-free copy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
      for (int e = 0; e < 16; e++) begin
        r_cfg[e]  <= '0;
        r_addr[e] <= '0;
        r_view[e] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cfg   <= w_cfg_nxt;
      r_addr  <= w_addr_nxt;
      r_view  <= w_view_nxt;
      if (w_acc) begin
        r_rdata <= w_rdata_nxt;
        r_err   <= w_err;
      end
    end
  end
  for (genvar g = 0; g < 16; g++) begin : g_out
    assign conf_o[8*g +: 8]                 = r_cfg[g];
    assign conf_addr_o[PMP_LEN*g +: PMP_LEN] = r_view[g];
  end
endmodule

// File: tb/tb_pmp_cfg_regs.sv
// tb_pmp_cfg_regs: directed and randomized checks of pmp_cfg_regs against a behavioural model
module tb_pmp_cfg_regs;
  localparam int NR = 16;
  localparam int PL = 54;
  localparam int G  = 2;
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             reg_valid_i = 1'b0;
  logic             reg_ready_o;
  logic             reg_write_i = 1'b0;
  logic [7:0]       reg_addr_i = '0;
  logic [63:0]      reg_wdata_i = '0;
  logic [7:0]       reg_wstrb_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [63:0]      rsp_rdata_o;
  logic             rsp_error_o;
  logic [16*8-1:0]  conf_o;
  logic [16*PL-1:0] conf_addr_o;
  int total = 0;
  int bad   = 0;
  logic [7:0]  m_cfg [16];
  logic [63:0] m_adr [16];
  logic [63:0] rd;
  logic        er;
  pmp_cfg_regs #(.NR_ENTRIES(NR), .PMP_LEN(PL), .PMPGranularity(G)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg_valid_i(reg_valid_i), .reg_ready_o(reg_ready_o),
    .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
    .reg_wstrb_i(reg_wstrb_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o), .conf_o(conf_o), .conf_addr_o(conf_addr_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit dec_ok(input logic [7:0] a);
    return a % 8 == 0 && (a < 16 || a >= 128);
  endfunction
  // address as the checker should see it: granule bits filled for NAPOT, cleared for OFF/TOR
  function automatic logic [63:0] view(input int i);
    logic [63:0] v = m_adr[i];
    int a = int'(m_cfg[i][4:3]);
    if (a == 3) return G > 0 ? v | ((64'd1 << (G - 1)) - 1) : v;
    if (a == 2) return v;
    return v & ~((64'd1 << G) - 1);
  endfunction
  function automatic logic [63:0] model_read(input logic [7:0] a);
    logic [63:0] r = '0;
    if (a < 16) begin
      for (int k = 0; k < 8; k++) r[8*k +: 8] = m_cfg[(a / 8) * 8 + k];
      return r;
    end
    return view((a - 128) / 8);
  endfunction
  task automatic model_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
    if (a < 16) begin
      for (int k = 0; k < 8; k++) begin
        int e = (a / 8) * 8 + k;
        logic [7:0] b = d[8*k +: 8];
        if (s[k] && e < NR && !m_cfg[e][7] && b[1:0] != 2'b10 && !(b[4:3] == 2'd2 && G >= 1))
          m_cfg[e] = b & 8'h9F;
      end
    end else begin
      int i = (a - 128) / 8;
      if (s == 8'hFF && !m_cfg[i][7] && !(i + 1 < NR && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'd1))
        m_adr[i] = d & ((64'd1 << PL) - 1);
    end
  endtask
  task automatic model_reset();
    for (int e = 0; e < 16; e++) begin
      m_cfg[e] = '0;
      m_adr[e] = '0;
    end
  endtask
  task automatic check_conf();
    for (int e = 0; e < 16; e++) begin
      chk($sformatf("conf[%0d]", e), 64'(conf_o[8*e +: 8]), 64'(m_cfg[e]));
      chk($sformatf("conf_addr[%0d]", e), 64'(conf_addr_o[PL*e +: PL]), view(e));
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
  endtask
  task automatic xact(input logic w, input logic [7:0] a, input logic [63:0] d, input logic [7:0] s,
                      input int hold, input bit keep, output logic [63:0] ord, output logic oer);
    logic [63:0] erd;
    logic eer;
    int n = 0;
    eer = !dec_ok(a);
    erd = (w || eer) ? 64'd0 : model_read(a);
    chk("ready_idle", 64'(reg_ready_o), 64'd1);
    reg_valid_i = 1'b1; reg_write_i = w; reg_addr_i = a; reg_wdata_i = d; reg_wstrb_i = s;
    @(posedge clk_i); #1;
    reg_valid_i = keep;
    while (!rsp_valid_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_ready", 64'(reg_ready_o), 64'd0);
      chk("hold_rdata", rsp_rdata_o, erd);
      @(posedge clk_i); #1;
    end
    chk("rdata", rsp_rdata_o, erd);
    chk("error", 64'(rsp_error_o), 64'(eer));
    ord = rsp_rdata_o;
    oer = rsp_error_o;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    reg_valid_i = 1'b0;
    chk("rsp_done", 64'(rsp_valid_o), 64'd0);
    if (w && !eer) model_write(a, d, s);
    check_conf();
  endtask
  initial begin
    model_reset();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst_ready", 64'(reg_ready_o), 64'd1);
    chk("rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rdata", rsp_rdata_o, 64'd0);
    chk("rst_error", 64'(rsp_error_o), 64'd0);
    check_conf();
    xact(0, 8'h00, 0, 0, 0, 0, rd, er);
    xact(0, 8'h08, 0, 0, 0, 0, rd, er);
    xact(0, 8'h80, 0, 0, 0, 0, rd, er);
    chk("rst_addr0", rd, 64'd0);
    xact(1, 8'h00, 64'h1F0B, 8'h03, 0, 0, rd, er);
    xact(0, 8'h00, 0, 0, 0, 0, rd, er);
    chk("cfg_rb", rd, 64'h1F0B);
    xact(1, 8'h00, 64'h8B00, 8'h02, 0, 0, rd, er);
    xact(1, 8'h80, 64'h1234, 8'hFF, 0, 0, rd, er);
    xact(1, 8'h00, 64'h0F00, 8'h02, 0, 0, rd, er);
    xact(0, 8'h00, 0, 0, 0, 0, rd, er);
    chk("lock_cfg", rd, 64'h8B0B);
    xact(1, 8'h88, 64'h55, 8'hFF, 0, 0, rd, er);
    xact(0, 8'h80, 0, 0, 0, 0, rd, er);
    chk("lock_addr0", rd, 64'd0);
    xact(0, 8'h88, 0, 0, 0, 0, rd, er);
    chk("lock_addr1", rd, 64'd0);
    do_reset();
    xact(1, 8'h00, 64'h12, 8'h01, 0, 0, rd, er);
    xact(1, 8'h00, 64'h02, 8'h01, 0, 0, rd, er);
    xact(0, 8'h00, 0, 0, 0, 0, rd, er);
    chk("warl_cfg", rd, 64'd0);
    xact(1, 8'h80, 64'hFF, 8'hFF, 0, 0, rd, er);
    xact(1, 8'h00, 64'h18, 8'h01, 0, 0, rd, er);
    xact(0, 8'h80, 0, 0, 0, 0, rd, er);
    chk("napot_view", rd, 64'hFF);
    xact(1, 8'h00, 64'h08, 8'h01, 0, 0, rd, er);
    xact(0, 8'h80, 0, 0, 0, 0, rd, er);
    chk("tor_view", rd, 64'hFC);
    xact(1, 8'h88, 64'h3FF, 8'h0F, 0, 0, rd, er);
    xact(0, 8'h80, 0, 0, 5, 1, rd, er);
    chk("bp_second_ready", 64'(reg_ready_o), 64'd1);
    xact(0, 8'h00, 0, 0, 0, 0, rd, er);
    chk("bp_second", rd, 64'h08);
    xact(0, 8'h04, 0, 0, 0, 0, rd, er);
    chk("err_04", 64'(er), 64'd1);
    xact(0, 8'h40, 0, 0, 0, 0, rd, er);
    chk("err_40", 64'(er), 64'd1);
    xact(1, 8'h40, 64'hFFFF, 8'hFF, 0, 0, rd, er);
    xact(1, 8'h0C, 64'hFFFF, 8'hFF, 0, 0, rd, er);
    for (int t = 0; t < 240; t++) begin
      logic [7:0] a, s;
      logic [63:0] d;
      int sel = $urandom_range(0, 9);
      if (t == 120) do_reset();
      d = {$urandom, $urandom};
      if (sel < 3) begin
        a = $urandom_range(0, 1) * 8;
        s = 8'($urandom);
        for (int k = 0; k < 8; k++) if ($urandom_range(0, 11) != 0) d[8*k+7] = 1'b0;
      end else if (sel < 9) begin
        a = 8'(8'h80 + 8 * $urandom_range(0, 15));
        s = $urandom_range(0, 3) != 0 ? 8'hFF : 8'($urandom);
      end else begin
        a = 8'($urandom);
        s = 8'($urandom);
      end
      xact(1'($urandom), a, d, s, $urandom_range(0, 3), 1'($urandom), rd, er);
    end
    xact(1, 8'h00, 64'h0F0F, 8'h03, 0, 0, rd, er);
    reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = 8'h00;
    @(posedge clk_i); #1;
    reg_valid_i = 1'b0;
    chk("pre_rst_valid", 64'(rsp_valid_o), 64'd1);
    chk("pre_rst_cfg", 64'(conf_o[15:0]), 64'h0F0F);
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("mid_rst_ready", 64'(reg_ready_o), 64'd1);
    chk("mid_rst_rdata", rsp_rdata_o, 64'd0);
    check_conf();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
